// File: rtl/alu_issue_if.sv
// Bundle between the ALU issue sequencer and its neighbours: instruction
// handshake, register-file load/debug access, ALU drive and result reporting.
interface alu_issue_if #(parameter int DW = 16);
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   in_instr;
   logic          ld_en;
   logic [2:0]    ld_addr;
   logic [DW-1:0] ld_data;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [3:0]    alu_sel;
   logic [DW-1:0] alu_out;
   logic          alu_zero;
   logic          done;
   logic [DW-1:0] res_data;
   logic          res_zero;
   logic          err;
   logic [2:0]    dbg_addr;
   logic [DW-1:0] dbg_data;

   modport master (
      output in_valid, in_instr, ld_en, ld_addr, ld_data, alu_out, alu_zero, dbg_addr,
      input  in_ready, alu_a, alu_b, alu_sel, done, res_data, res_zero, err, dbg_data
   );

   modport slave (
      input  in_valid, in_instr, ld_en, ld_addr, ld_data, alu_out, alu_zero, dbg_addr,
      output in_ready, alu_a, alu_b, alu_sel, done, res_data, res_zero, err, dbg_data
   );
endinterface

// File: rtl/alu_issue_seq.sv
// Four-state sequencer: accepts a register-register instruction, reads two
// operands from an 8x16 register file, drives an external ALU and writes back.
module alu_issue_seq #(
   parameter int NREG = 8,
   parameter int DW   = 16
) (
   input  logic      clk,
   input  logic      rst,
   alu_issue_if.slave bus
);
   localparam int AW = 3;

   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

   state_t        state_reg, state_next;
   logic [3:0]    func_reg;
   logic [AW-1:0] dst_reg, src1_reg, src2_reg;
   logic          illegal_reg;
   logic [DW-1:0] result_reg;
   logic [DW-1:0] rf_reg [NREG];
   logic [DW-1:0] alu_a_reg, alu_b_reg;
   logic [3:0]    alu_sel_reg;
   logic          done_reg, err_reg, res_zero_reg;
   logic [DW-1:0] res_data_reg;

   logic          accept;
   logic          func_is_cmp;
   logic [DW-1:0] op_a, op_b, exec_result;
   logic          rf_wr_en;
   logic [AW-1:0] rf_wr_addr;
   logic [DW-1:0] rf_wr_data;

   function automatic logic [3:0] decode_sel(input logic [3:0] f);
      case (f)
         4'd0:    return 4'b0000;
         4'd1:    return 4'b1010;
         4'd2:    return 4'b0100;
         4'd3:    return 4'b0110;
         4'd4:    return 4'b0111;
         4'd5:    return 4'b1000;
         4'd6:    return 4'b1001;
         4'd7:    return 4'b1100;
         4'd8:    return 4'b1101;
         4'd9:    return 4'b1110;
         4'd10:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   assign bus.in_ready = (state_reg == IDLE) && !bus.ld_en;
   assign accept       = bus.in_valid && bus.in_ready;

   assign op_a         = (src1_reg == '0) ? '0 : rf_reg[src1_reg];
   assign op_b         = (src2_reg == '0) ? '0 : rf_reg[src2_reg];
   assign bus.dbg_data = (bus.dbg_addr == '0) ? '0 : rf_reg[bus.dbg_addr];

   assign func_is_cmp  = (func_reg >= 4'd5) && (func_reg <= 4'd10);
   assign exec_result  = func_is_cmp ? {{(DW-1){1'b0}}, bus.alu_out[0]} : bus.alu_out;

   assign bus.alu_a    = alu_a_reg;
   assign bus.alu_b    = alu_b_reg;
   assign bus.alu_sel  = alu_sel_reg;
   assign bus.done     = done_reg;
   assign bus.err      = err_reg;
   assign bus.res_data = res_data_reg;
   assign bus.res_zero = res_zero_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = READ;
         READ:    state_next = EXEC;
         EXEC:    state_next = WB;
         WB:      state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Writeback and loads share one write port; they never coincide since
   // loads are only honoured in IDLE.
   always_comb begin
      rf_wr_en   = 1'b0;
      rf_wr_addr = bus.ld_addr;
      rf_wr_data = bus.ld_data;
      if (state_reg == WB) begin
         rf_wr_en   = !illegal_reg;
         rf_wr_addr = dst_reg;
         rf_wr_data = result_reg;
      end else if (state_reg == IDLE && bus.ld_en) begin
         rf_wr_en   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) rf_reg[i] <= '0;
      end else if (rf_wr_en && rf_wr_addr != '0) begin
         rf_reg[rf_wr_addr] <= rf_wr_data;
      end
   end

   // Result flags are registered on the EXEC->WB edge so they are already
   // valid during the WB cycle that carries the done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         func_reg     <= '0;
         dst_reg      <= '0;
         src1_reg     <= '0;
         src2_reg     <= '0;
         illegal_reg  <= 1'b0;
         result_reg   <= '0;
         alu_a_reg    <= '0;
         alu_b_reg    <= '0;
         alu_sel_reg  <= '0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         res_data_reg <= '0;
         res_zero_reg <= 1'b1;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  func_reg <= bus.in_instr[15:12];
                  dst_reg  <= bus.in_instr[11:9];
                  src1_reg <= bus.in_instr[8:6];
                  src2_reg <= bus.in_instr[5:3];
               end
            end
            READ: begin
               alu_a_reg   <= op_a;
               alu_b_reg   <= op_b;
               alu_sel_reg <= decode_sel(func_reg);
               illegal_reg <= (func_reg > 4'd10);
            end
            EXEC: begin
               result_reg   <= exec_result;
               done_reg     <= 1'b1;
               err_reg      <= illegal_reg;
               res_data_reg <= illegal_reg ? '0 : exec_result;
               res_zero_reg <= illegal_reg ? 1'b1 : (exec_result == '0);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: behavioural ALU, table-driven directed vectors,
// multi-cycle corner sequences and randomized checks against a register model.
module tb_alu_issue_seq;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic [15:0] ref_rf [8];
   logic [15:0] alu_res;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_issue_if #(.DW(16)) bus();
   alu_issue_seq #(.NREG(8), .DW(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   // External ALU as seen by the sequencer.
   always_comb begin
      alu_res = 16'h0;
      case (bus.alu_sel)
         4'b0000: alu_res = bus.alu_a + bus.alu_b;
         4'b1010: alu_res = bus.alu_a - bus.alu_b;
         4'b0100: alu_res = bus.alu_a ^ bus.alu_b;
         4'b0110: alu_res = bus.alu_a | bus.alu_b;
         4'b0111: alu_res = bus.alu_a & bus.alu_b;
         4'b1000: alu_res = {15'b0, bus.alu_a == bus.alu_b};
         4'b1001: alu_res = {15'b0, bus.alu_a != bus.alu_b};
         4'b1100: alu_res = {15'b0, $signed(bus.alu_a) <  $signed(bus.alu_b)};
         4'b1101: alu_res = {15'b0, $signed(bus.alu_a) >= $signed(bus.alu_b)};
         4'b1110: alu_res = {15'b0, bus.alu_a <  bus.alu_b};
         4'b1111: alu_res = {15'b0, bus.alu_a >= bus.alu_b};
         default: alu_res = 16'h0;
      endcase
      bus.alu_out  = alu_res;
      bus.alu_zero = (alu_res == 16'h0);
   end

   typedef struct {
      logic [15:0] r1v;
      logic [15:0] r2v;
      logic [3:0]  func;
      logic [2:0]  rd;
      logic [2:0]  rs1;
      logic [2:0]  rs2;
      logic [15:0] exp_res;
      logic        exp_zero;
      logic        exp_err;
      logic [3:0]  exp_sel;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void ref_exec(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] r, output logic ill);
      ill = 1'b0;
      case (f)
         4'd0:    r = a + b;
         4'd1:    r = a - b;
         4'd2:    r = a ^ b;
         4'd3:    r = a | b;
         4'd4:    r = a & b;
         4'd5:    r = (a == b) ? 16'd1 : 16'd0;
         4'd6:    r = (a != b) ? 16'd1 : 16'd0;
         4'd7:    r = ($signed(a) <  $signed(b)) ? 16'd1 : 16'd0;
         4'd8:    r = ($signed(a) >= $signed(b)) ? 16'd1 : 16'd0;
         4'd9:    r = (a <  b) ? 16'd1 : 16'd0;
         4'd10:   r = (a >= b) ? 16'd1 : 16'd0;
         default: begin r = 16'd0; ill = 1'b1; end
      endcase
   endfunction

   function automatic logic [15:0] mk(input logic [3:0] f, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
      return {f, rd, rs1, rs2, 3'b000};
   endfunction

   task automatic load(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
      @(negedge clk);
      bus.ld_en = 1'b0;
      if (a != 3'd0) ref_rf[a] = d;
   endtask

   task automatic read_dbg(input logic [2:0] a, output logic [15:0] d);
      bus.dbg_addr = a;
      #1;
      d = bus.dbg_data;
   endtask

   task automatic issue(input logic [15:0] instr, output logic [15:0] res, output logic z,
                        output logic e, output logic [3:0] sel_exec, output int lat, output int done_at);
      int k;
      res = 16'h0; z = 1'b0; e = 1'b0; sel_exec = 4'h0; lat = -1; done_at = -1;
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_instr = instr;
      k = 0;
      while (!bus.in_ready && k < 20) begin @(negedge clk); k++; end
      check("in_ready_wait", bus.in_ready, 1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      k = 1;
      while (lat < 0 && k <= 8) begin
         @(negedge clk);
         if (k == 2) sel_exec = bus.alu_sel;
         if (bus.done) begin
            lat = k; done_at = cyc; res = bus.res_data; z = bus.res_zero; e = bus.err;
         end
         k++;
      end
   endtask

   task automatic exec_check(input string tag, input logic [15:0] instr, input logic [15:0] exp_res,
                             input logic exp_zero, input logic exp_err, input logic chk_sel,
                             input logic [3:0] exp_sel);
      logic [15:0] res, r, d;
      logic z, e, ill;
      logic [3:0] sel;
      int lat, dat;
      ref_exec(instr[15:12], ref_rf[instr[8:6]], ref_rf[instr[5:3]], r, ill);
      issue(instr, res, z, e, sel, lat, dat);
      check({tag, "_latency"}, lat, 3);
      check({tag, "_res"}, res, exp_res);
      check({tag, "_zero"}, z, exp_zero);
      check({tag, "_err"}, e, exp_err);
      if (chk_sel) check({tag, "_sel"}, sel, exp_sel);
      if (!ill && instr[11:9] != 3'd0) ref_rf[instr[11:9]] = r;
      @(negedge clk);
      check({tag, "_done_pulse"}, bus.done, 0);
      read_dbg(instr[11:9], d);
      check({tag, "_rd_value"}, d, ref_rf[instr[11:9]]);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d, res, r;
      logic z, e, ill, seen;
      logic [3:0] sel;
      int lat, dat1, dat2;

      vecs[0]  = '{16'h7FFF, 16'h0001, 4'd0,  3'd3, 3'd1, 3'd2, 16'h8000, 1'b0, 1'b0, 4'b0000};
      vecs[1]  = '{16'hFFFF, 16'h0001, 4'd7,  3'd5, 3'd1, 3'd2, 16'h0001, 1'b0, 1'b0, 4'b1100};
      vecs[2]  = '{16'hFFFF, 16'h0001, 4'd9,  3'd5, 3'd1, 3'd2, 16'h0000, 1'b1, 1'b0, 4'b1110};
      vecs[3]  = '{16'hFFFF, 16'h0001, 4'd1,  3'd6, 3'd1, 3'd1, 16'h0000, 1'b1, 1'b0, 4'b1010};
      vecs[4]  = '{16'hFFFF, 16'h0001, 4'd12, 3'd4, 3'd1, 3'd2, 16'h0000, 1'b1, 1'b1, 4'b0000};
      vecs[5]  = '{16'h1234, 16'h0101, 4'd0,  3'd0, 3'd1, 3'd2, 16'h1335, 1'b0, 1'b0, 4'b0000};
      vecs[6]  = '{16'hF0F0, 16'h0FF0, 4'd2,  3'd7, 3'd1, 3'd2, 16'hFF00, 1'b0, 1'b0, 4'b0100};
      vecs[7]  = '{16'hFFFF, 16'h0001, 4'd8,  3'd3, 3'd1, 3'd2, 16'h0000, 1'b1, 1'b0, 4'b1101};
      vecs[8]  = '{16'hFFFF, 16'h0001, 4'd10, 3'd3, 3'd1, 3'd2, 16'h0001, 1'b0, 1'b0, 4'b1111};
      vecs[9]  = '{16'h0005, 16'h0005, 4'd5,  3'd6, 3'd1, 3'd2, 16'h0001, 1'b0, 1'b0, 4'b1000};
      vecs[10] = '{16'h0005, 16'h0005, 4'd6,  3'd6, 3'd1, 3'd2, 16'h0000, 1'b1, 1'b0, 4'b1001};
      vecs[11] = '{16'h00F0, 16'h0F00, 4'd3,  3'd7, 3'd1, 3'd2, 16'h0FF0, 1'b0, 1'b0, 4'b0110};
      vecs[12] = '{16'hF0F0, 16'h0FF0, 4'd4,  3'd7, 3'd1, 3'd2, 16'h00F0, 1'b0, 1'b0, 4'b0111};
      vecs[13] = '{16'hFFFF, 16'h0001, 4'd0,  3'd4, 3'd1, 3'd2, 16'h0000, 1'b1, 1'b0, 4'b0000};

      for (int i = 0; i < 8; i++) ref_rf[i] = 16'h0;
      bus.in_valid = 1'b0; bus.in_instr = 16'h0; bus.ld_en = 1'b0;
      bus.ld_addr = 3'd0; bus.ld_data = 16'h0; bus.dbg_addr = 3'd0;
      rst = 1'b1;
      #1;
      check("reset_alu_a", bus.alu_a, 0);
      check("reset_alu_sel", bus.alu_sel, 0);
      check("reset_done", bus.done, 0);
      check("reset_res_zero", bus.res_zero, 1);
      check("reset_res_data", bus.res_data, 0);
      check("reset_in_ready", bus.in_ready, 1);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // Reset while an ADD sits in EXEC.
      load(3'd1, 16'h0011);
      load(3'd2, 16'h0022);
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_instr = mk(4'd0, 3'd3, 3'd1, 3'd2);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      check("midreset_exec_a", bus.alu_a, 16'h0011);
      rst = 1'b1;
      #1;
      check("midreset_alu_a", bus.alu_a, 0);
      check("midreset_alu_b", bus.alu_b, 0);
      check("midreset_done", bus.done, 0);
      check("midreset_res_zero", bus.res_zero, 1);
      check("midreset_err", bus.err, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) ref_rf[i] = 16'h0;
      @(negedge clk);
      check("midreset_ready_after", bus.in_ready, 1);
      seen = 1'b0;
      repeat (5) begin @(negedge clk); if (bus.done) seen = 1'b1; end
      check("midreset_no_done", seen, 0);
      read_dbg(3'd3, d);
      check("midreset_r3", d, 16'h0);

      // Directed table.
      load(3'd4, 16'hBEEF);
      for (int i = 0; i < 14; i++) begin
         load(3'd1, vecs[i].r1v);
         load(3'd2, vecs[i].r2v);
         exec_check($sformatf("vec%0d", i), mk(vecs[i].func, vecs[i].rd, vecs[i].rs1, vecs[i].rs2),
                    vecs[i].exp_res, vecs[i].exp_zero, vecs[i].exp_err, 1'b1, vecs[i].exp_sel);
      end
      read_dbg(3'd0, d);
      check("dbg_r0", d, 16'h0);

      // Load and instruction in the same IDLE cycle: load wins.
      @(negedge clk);
      bus.ld_en = 1'b1; bus.ld_addr = 3'd2; bus.ld_data = 16'h00AA;
      bus.in_valid = 1'b1; bus.in_instr = mk(4'd0, 3'd3, 3'd1, 3'd2);
      #1;
      check("collide_ready_low", bus.in_ready, 0);
      @(posedge clk);
      #1 bus.ld_en = 1'b0; bus.in_valid = 1'b0;
      ref_rf[2] = 16'h00AA;
      @(negedge clk);
      check("collide_not_accepted", bus.in_ready, 1);
      seen = 1'b0;
      repeat (5) begin @(negedge clk); if (bus.done) seen = 1'b1; end
      check("collide_no_done", seen, 0);
      read_dbg(3'd2, d);
      check("collide_load_r2", d, 16'h00AA);

      // Back-to-back dependent ADDs.
      load(3'd1, 16'h0003);
      load(3'd2, 16'h0004);
      issue(mk(4'd0, 3'd3, 3'd1, 3'd2), res, z, e, sel, lat, dat1);
      check("b2b_first_res", res, 16'h0007);
      issue(mk(4'd0, 3'd4, 3'd3, 3'd3), res, z, e, sel, lat, dat2);
      check("b2b_second_res", res, 16'h000E);
      check("b2b_done_gap", dat2 - dat1, 4);
      ref_rf[3] = 16'h0007; ref_rf[4] = 16'h000E;
      @(negedge clk);
      read_dbg(3'd4, d);
      check("b2b_r4", d, 16'h000E);

      // Randomized instructions against the register model.
      for (int it = 0; it < 60; it++) begin
         logic [3:0] f;
         logic [2:0] rd, rs1, rs2;
         load(3'($urandom_range(0, 7)), 16'($urandom));
         f = 4'($urandom_range(0, 15));
         rd = 3'($urandom_range(0, 7));
         rs1 = 3'($urandom_range(0, 7));
         rs2 = 3'($urandom_range(0, 7));
         ref_exec(f, ref_rf[rs1], ref_rf[rs2], r, ill);
         if (ill) r = 16'h0;
         exec_check($sformatf("rnd%0d", it), mk(f, rd, rs1, rs2), r, r == 16'h0, ill, 1'b0, 4'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Multi-cycle operation sequencer that drives the team's 16-bit combinational ALU as its initiator.
- Accepts one 16-bit register-register instruction per valid/ready handshake and reads two operands from an internal 8x16 register file.
- Decodes a 4-bit function code to the 4-bit ALU select encoding, drives the external ALU, captures the result, writes it back, then reports completion.
- Sits between instruction fetch and the ALU instance.

Parameters:
- NREG, 8, register file depth; fixed power of two; index width is 3.
- DW, 16, datapath width; must match the ALU operand width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction valid
- in_ready  out  1  high while able to accept an instruction
- in_instr  in  16  [15:12] func, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] ignored
- ld_en  in  1  register-file load strobe
- ld_addr  in  3  load index
- ld_data  in  16  load data
- alu_a  out  16  ALU operand A (registered)
- alu_b  out  16  ALU operand B (registered)
- alu_sel  out  4  ALU select (registered)
- alu_out  in  16  ALU result
- alu_zero  in  1  ALU zero flag; captured but not used for res_zero
- done  out  1  one-cycle completion pulse
- res_data  out  16  value written back; held until next done
- res_zero  out  1  high when res_data==0; held with res_data
- err  out  1  illegal func flag; valid with done
- dbg_addr  in  3  debug read index
- dbg_data  out  16  combinational read of reg[dbg_addr]; reg 0 reads 0

Behaviour:
- Reset (async, any state): FSM=IDLE; all register-file entries=0; alu_a=0, alu_b=0, alu_sel=0; done=0, err=0, res_data=0, res_zero=1.
- in_ready = (state==IDLE) & ~ld_en.
- A reset mid-operation abandons the instruction with no writeback and no done.
- Func decode to alu_sel:
  - 0 ADD->0000, 1 SUB->1010, 2 XOR->0100, 3 OR->0110, 4 AND->0111
  - 5 EQ->1000, 6 NE->1001
  - 7 SLT->1100, 8 SGE->1101 (signed)
  - 9 SLTU->1110, 10 SGEU->1111 (unsigned)
  - 11-15 illegal.
- FSM, states IDLE, READ, EXEC, WB:
  - IDLE: on in_valid&in_ready, latch in_instr -> READ. Otherwise, if ld_en, write reg[ld_addr]=ld_data; writes to index 0 are dropped.
  - READ: alu_a<=reg[rs1], alu_b<=reg[rs2], alu_sel<=decoded value. For illegal func, alu_sel<=0000 and the illegal flag is latched. -> EXEC.
  - EXEC: ALU inputs are stable for the full cycle; capture alu_out into the result register. For compare funcs (5-10), capture {15'b0, alu_out[0]}. -> WB.
  - WB: if legal and rd!=0, write reg[rd]=result. Pulse done=1. Update res_data=result and res_zero=(result==0). err=illegal. For illegal func, res_data=0, res_zero=1, and no write occurs. -> IDLE.
- Latency: handshake in cycle N -> done high in cycle N+3. Throughput is 1 instruction per 4 cycles; in_ready is low in READ/EXEC/WB.
- Hazards: rs1/rs2 equal to the previous rd see the written value, because WB completes before the next READ.
- Same-cycle collision: ld_en and in_valid together in IDLE -> load wins and the instruction is not accepted (in_ready=0).
- ld_en outside IDLE is ignored.
- Register 0 always reads 0, on operand reads and on dbg_data.
- Arithmetic wraps modulo 2^16 inside the ALU; the sequencer does no width extension.
- alu_a, alu_b and alu_sel hold their last value in IDLE.

Test Plan:
- Reset in the middle of EXEC of an ADD -> all outputs return to reset values, no done pulse, rd unchanged (checked via dbg_data), in_ready=1 on the cycle after reset deasserts.
- Load r1=0x7FFF, r2=0x0001; issue ADD rd=3 -> alu_sel=0000 during EXEC, done at N+3, res_data=0x8000, res_zero=0, reg3=0x8000.
- Load r1=0xFFFF, r2=0x0001:
  - SLT -> res_data=0x0001
  - SLTU -> res_data=0x0000, res_zero=1
  - SUB r1,r1 -> res_data=0, res_zero=1
- Func=12 with rd=4 -> done with err=1, res_data=0, reg4 unchanged, alu_sel=0000.
- ADD targeting rd=0 -> done with correct res_data, dbg_data(0)=0.
- ld_en and in_valid asserted in the same IDLE cycle -> load written, instruction not accepted. Back-to-back dependent ADDs (r3=r1+r2, then r4=r3+r3) -> r4 uses the updated r3; second done lands 4 cycles after the first.
